float2fix_sched: RTL and testbench

Shared-converter scheduler for the float-to-fixed datapath. Two independent requesters submit IEEE-754 single-precision operands with a fixed-point position. The block round-robin arbitrates between them and sequences one shared combinational `float2fix` instance through an operand register and a result register. It presents each result, tagged with the requester ID, on a valid/ready output port and keeps per-requester completion counters.

---
 rtl/float2fix_sched.sv | 146 ++++++++++++++
 tb/tb_float2fix_sched.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/float2fix_sched.sv
// Round-robin scheduler that shares one combinational float-to-fixed converter
// between two requesters and returns ID-tagged results on a valid/ready port.

module float2fix (
  input  logic [31:0] floatn,
  input  logic [4:0]  fixposition,
  output logic [31:0] fixn
);
  logic [7:0]        exp_eff;
  logic [31:0]       mag;
  logic signed [9:0] sh;
  logic [9:0]        lsh;
  logic [9:0]        rsh;
  logic [31:0]       absval;

  // Value = mag * 2^(exp - 150 + pos); subnormals use exponent 1 with no hidden bit.
  always_comb begin
    exp_eff = (floatn[30:23] == 8'd0) ? 8'd1 : floatn[30:23];
    mag     = {8'd0, (floatn[30:23] != 8'd0), floatn[22:0]};
    sh      = $signed({2'b00, exp_eff}) + $signed({5'b00000, fixposition}) - 10'sd150;
    lsh     = sh;
    rsh     = -sh;
    absval  = 32'd0;
    if (sh >= 10'sd32) begin
      absval = 32'd0;
    end else if (sh >= 10'sd0) begin
      absval = mag << lsh;
    end else if (sh > -10'sd24) begin
      absval = mag >> rsh;
    end
    fixn = floatn[31] ? -absval : absval;
  end
endmodule

module float2fix_sched #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_float,
  input  logic [4:0]       req0_pos,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_float,
  input  logic [4:0]       req1_pos,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_fix,
  output logic             out_id,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);
  typedef enum logic [1:0] {IDLE, CONVERT, HOLD} state_t;

  state_t      state;
  state_t      state_next;
  logic        ptr;
  logic        grant_valid;
  logic        grant_id;
  logic        accept;
  logic [31:0] op_float;
  logic [4:0]  op_pos;
  logic        op_id;
  logic [31:0] fixn;

  float2fix u_conv (
    .floatn      (op_float),
    .fixposition (op_pos),
    .fixn        (fixn)
  );

  // ptr names the requester that wins when both are valid.
  always_comb begin
    grant_valid = req0_valid | req1_valid;
    grant_id    = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ptr;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
    req0_ready = (state == IDLE) && grant_valid && !grant_id;
    req1_ready = (state == IDLE) && grant_valid && grant_id;
    accept     = req0_ready | req1_ready;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = CONVERT;
      CONVERT: state_next = HOLD;
      HOLD:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= 1'b0;
      op_float  <= 32'd0;
      op_pos    <= 5'd0;
      op_id     <= 1'b0;
      out_valid <= 1'b0;
      out_fix   <= 32'd0;
      out_id    <= 1'b0;
      cnt0      <= '0;
      cnt1      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_float <= grant_id ? req1_float : req0_float;
            op_pos   <= grant_id ? req1_pos : req0_pos;
            op_id    <= grant_id;
            ptr      <= !grant_id;
          end
        end
        CONVERT: begin
          out_fix   <= fixn;
          out_id    <= op_id;
          out_valid <= 1'b1;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_id) begin
              cnt1 <= cnt1 + CNT_W'(1);
            end else begin
              cnt0 <= cnt0 + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_float2fix_sched.sv
// Directed bench for float2fix_sched: conversions, round-robin, back-pressure,
// mid-operation reset and counter wrap on a CNT_W=2 instance.

module tb_float2fix_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0;
  logic        req1_valid = 1'b0;
  logic [31:0] req0_float = 32'd0;
  logic [31:0] req1_float = 32'd0;
  logic [4:0]  req0_pos = 5'd0;
  logic [4:0]  req1_pos = 5'd0;
  logic        out_ready = 1'b0;

  logic        req0_ready, req1_ready, out_valid, out_id;
  logic [31:0] out_fix;
  logic [15:0] cnt0, cnt1;

  logic        s_req0_ready, s_req1_ready, s_out_valid, s_out_id;
  logic [31:0] s_out_fix;
  logic [1:0]  s_cnt0, s_cnt1;

  int n_compared = 0;
  int n_mismatched = 0;
  int cnt0_exp = 0;
  int cnt1_exp = 0;

  always #5 clk = ~clk;

  float2fix_sched #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_float(req0_float), .req0_pos(req0_pos),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_float(req1_float), .req1_pos(req1_pos),
    .out_valid(out_valid), .out_ready(out_ready), .out_fix(out_fix), .out_id(out_id),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  float2fix_sched #(.CNT_W(2)) dut_small (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(s_req0_ready), .req0_float(req0_float), .req0_pos(req0_pos),
    .req1_valid(req1_valid), .req1_ready(s_req1_ready), .req1_float(req1_float), .req1_pos(req1_pos),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_fix(s_out_fix), .out_id(s_out_id),
    .cnt0(s_cnt0), .cnt1(s_cnt1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [31:0] f0, input logic [4:0] p0,
                               input logic v1, input logic [31:0] f1, input logic [4:0] p1,
                               input logic ordy);
    req0_valid = v0; req0_float = f0; req0_pos = p0;
    req1_valid = v1; req1_float = f1; req1_pos = p1;
    out_ready  = ordy;
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, "_cnt0"}, 32'(cnt0), 32'(cnt0_exp));
    checkOutput({tag, "_cnt1"}, 32'(cnt1), 32'(cnt1_exp));
    checkOutput({tag, "_small_cnt0"}, 32'(s_cnt0), 32'(cnt0_exp % 4));
  endtask

  // Called at a negedge with the DUT in IDLE; returns at a negedge back in IDLE.
  task automatic doConvert(input logic id, input logic [31:0] f, input logic [4:0] p,
                           input logic [31:0] exp_fix);
    if (id) applyStimulus(1'b0, 32'd0, 5'd0, 1'b1, f, p, 1'b0);
    else    applyStimulus(1'b1, f, p, 1'b0, 32'd0, 5'd0, 1'b0);
    #1;
    checkOutput("accept_ready0", 32'(req0_ready), 32'(!id));
    checkOutput("accept_ready1", 32'(req1_ready), 32'(id));
    @(posedge clk); @(negedge clk);
    applyStimulus(1'b1, 32'h3F800000, 5'd0, 1'b1, 32'h3F800000, 5'd0, 1'b0);
    checkOutput("convert_valid", 32'(out_valid), 32'd0);
    checkOutput("convert_ready0", 32'(req0_ready), 32'd0);
    @(posedge clk); @(negedge clk);
    checkOutput("hold_valid", 32'(out_valid), 32'd1);
    checkOutput("hold_fix", out_fix, exp_fix);
    checkOutput("hold_id", 32'(out_id), 32'(id));
    checkOutput("hold_ready1", 32'(req1_ready), 32'd0);
    applyStimulus(1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 5'd0, 1'b1);
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    if (id) cnt1_exp++; else cnt0_exp++;
    checkOutput("consume_valid", 32'(out_valid), 32'd0);
    checkCounters("consume");
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    applyStimulus(1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 5'd0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_fix", out_fix, 32'd0);
    checkOutput("rst_id", 32'(out_id), 32'd0);
    checkCounters("rst");
    checkOutput("rst_ready0_idle", 32'(req0_ready), 32'd0);
    req0_valid = 1'b1;
    #1;
    checkOutput("rst_ready0_follows_valid", 32'(req0_ready), 32'd1);
    checkOutput("rst_ready1", 32'(req1_ready), 32'd0);
    @(negedge clk);
    req0_valid = 1'b0;
    rst = 1'b0;

    doConvert(1'b0, 32'hC0E00000, 5'd0, 32'hFFFFFFF9);
    doConvert(1'b0, 32'h41200000, 5'd4, 32'h000000A0);
    doConvert(1'b0, 32'h4B000000, 5'd3, 32'h04000000);
    doConvert(1'b1, 32'h3FC00000, 5'd8, 32'h00000180);
    doConvert(1'b1, 32'hBFC00000, 5'd1, 32'hFFFFFFFD);

    // Both requesters valid, consumer always ready: grants alternate every 3 cycles.
    applyStimulus(1'b1, 32'h40000000, 5'd0, 1'b1, 32'hC0400000, 5'd0, 1'b1);
    for (int g = 0; g < 6; g++) begin
      #1;
      checkOutput("rr_ready0", 32'(req0_ready), 32'(g % 2 == 0));
      checkOutput("rr_ready1", 32'(req1_ready), 32'(g % 2 == 1));
      @(posedge clk); @(negedge clk);
      checkOutput("rr_convert_valid", 32'(out_valid), 32'd0);
      @(posedge clk); @(negedge clk);
      checkOutput("rr_hold_id", 32'(out_id), 32'(g % 2));
      checkOutput("rr_hold_fix", out_fix, (g % 2 == 0) ? 32'h00000002 : 32'hFFFFFFFD);
      @(posedge clk); @(negedge clk);
      if (g % 2 == 1) cnt1_exp++; else cnt0_exp++;
      checkCounters("rr");
    end
    applyStimulus(1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 5'd0, 1'b0);
    checkOutput("rr_total_cnt0", 32'(cnt0), 32'd6);
    checkOutput("rr_total_cnt1", 32'(cnt1), 32'd5);

    // Back-pressure: result must stay put while requesters keep asking.
    applyStimulus(1'b1, 32'h40000000, 5'd1, 1'b1, 32'hC0400000, 5'd0, 1'b0);
    #1;
    checkOutput("bp_accept_ready0", 32'(req0_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      checkOutput("bp_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_fix", out_fix, 32'h00000004);
      checkOutput("bp_id", 32'(out_id), 32'd0);
      checkOutput("bp_ready0", 32'(req0_ready), 32'd0);
      checkOutput("bp_ready1", 32'(req1_ready), 32'd0);
      checkCounters("bp");
      @(posedge clk); @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    cnt0_exp++;
    checkOutput("bp_release_valid", 32'(out_valid), 32'd0);
    checkOutput("bp_release_idle_ready1", 32'(req1_ready), 32'd1);
    checkCounters("bp_release");
    applyStimulus(1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 5'd0, 1'b0);

    // Reset during CONVERT.
    applyStimulus(1'b1, 32'h40000000, 5'd0, 1'b0, 32'd0, 5'd0, 1'b0);
    @(posedge clk); @(negedge clk);
    applyStimulus(1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 5'd0, 1'b0);
    rst = 1'b1;
    cnt0_exp = 0;
    cnt1_exp = 0;
    #1;
    checkOutput("rst_convert_valid", 32'(out_valid), 32'd0);
    checkCounters("rst_convert");
    @(negedge clk);
    rst = 1'b0;

    // Reset during HOLD: out_valid must fall without waiting for a clock.
    applyStimulus(1'b1, 32'h40000000, 5'd0, 1'b0, 32'd0, 5'd0, 1'b0);
    @(posedge clk); @(negedge clk);
    applyStimulus(1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 5'd0, 1'b0);
    @(posedge clk); @(negedge clk);
    checkOutput("pre_rst_hold_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rst_hold_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_hold_fix", out_fix, 32'd0);
    checkCounters("rst_hold");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Pointer was cleared, so requester 0 wins a tie even though it was granted last.
    applyStimulus(1'b1, 32'h40000000, 5'd0, 1'b1, 32'h40000000, 5'd0, 1'b0);
    #1;
    checkOutput("ptr_reset_ready0", 32'(req0_ready), 32'd1);
    checkOutput("ptr_reset_ready1", 32'(req1_ready), 32'd0);
    applyStimulus(1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 5'd0, 1'b0);
    @(negedge clk);

    doConvert(1'b1, 32'h3FC00000, 5'd8, 32'h00000180);

    // Five req0 results: the CNT_W=2 instance walks 1,2,3,0,1.
    for (int k = 0; k < 5; k++) begin
      doConvert(1'b0, 32'h40000000, 5'd0, 32'h00000002);
      checkOutput("wrap_small_cnt0", 32'(s_cnt0), 32'((k + 1) % 4));
    end

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
